// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the pipeline register file with pending scoreboard.
package regfile_sb_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned NUM_RD_DEF   = 2;
  localparam int unsigned SPEC_REG_DEF = 15;
  localparam int unsigned RST_VAL      = 0;

endpackage

// File: rtl/regfile_sb_score.sv
// Pending scoreboard: per-register pending bits, pending count and sticky writeback error.
module regfile_sb_score
  import regfile_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   setEn,
  input  logic [ADDR_W-1:0]      setAddr,
  input  logic                   clrEn,
  input  logic [ADDR_W-1:0]      clrAddr,
  input  logic                   errClr,
  output logic [2**ADDR_W-1:0]   pending,
  output logic [ADDR_W:0]        pendCnt,
  output logic                   wbErr
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [2**ADDR_W-1:0] pendNext;
  logic                 cntInc;
  logic                 cntDec;
  logic                 errSet;

  // Next pending vector; a new issue overrides a same-cycle retire
  always_comb begin
    pendNext = pending;
    cntInc   = 1'b0;
    cntDec   = 1'b0;
    errSet   = 1'b0;
    if (clrEn) pendNext[clrAddr] = 1'b0;
    if (setEn) pendNext[setAddr] = 1'b1;
    cntInc = setEn && !pending[setAddr];
    cntDec = clrEn && pending[clrAddr] && !(setEn && (setAddr == clrAddr));
    errSet = clrEn && !pending[clrAddr];
  end

  // Scoreboard state; error set dominates clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      pendCnt <= '0;
      wbErr   <= 1'b0;
    end else begin
      pending <= pendNext;
      pendCnt <= pendCnt + CNT_W'(cntInc) - CNT_W'(cntDec);
      wbErr   <= errSet | (wbErr & ~errClr);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with general + special write ports and RAW/WAW pending scoreboard.
// Optional same-cycle write forwarding enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned SPEC_REG = SPEC_REG_DEF,
  parameter bit          ZERO_R0  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [DATA_W-1:0]        spec_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     spec_wr_en,
  input  logic [DATA_W-1:0]        spec_wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     stall,
  output logic [ADDR_W:0]          pend_cnt,
  output logic                     wb_err,
  input  logic                     err_clr
);

  localparam int unsigned       NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SPEC_IDX = ADDR_W'(SPEC_REG);

  logic [DATA_W-1:0]   regFile [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                wrEff;
  logic                specEff;
  logic                issueEff;
  logic                specZero;
  logic                specFwdWr;
  logic                specFwdSpec;

  // Register 0 discards writes/issues when hardwired to zero; general port wins a collision on SPEC_REG
  assign wrEff    = wr_en && !(ZERO_R0 && (wr_addr == '0));
  assign specZero = ZERO_R0 && (SPEC_IDX == '0);
  assign specEff  = spec_wr_en && !specZero && !(wr_en && (wr_addr == SPEC_IDX));
  assign issueEff = issue_en && !stall && !(ZERO_R0 && (issue_addr == '0));

  // Register array with both write ports; collision already resolved in specEff
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regFile[i] <= DATA_W'(RST_VAL);
    end else begin
      if (wrEff)   regFile[wr_addr]  <= wr_data;
      if (specEff) regFile[SPEC_IDX] <= spec_wr_data;
    end
  end

  // Read ports: array read with optional forwarding from this cycle's writes
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zeroHit;
    logic              fwdWr;
    logic              fwdSpec;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign zeroHit = ZERO_R0 && (addr == '0);
`ifdef REGFILE_SB_BYPASS_EN
    assign fwdWr   = wrEff && (wr_addr == addr);
    assign fwdSpec = specEff && (addr == SPEC_IDX);
`else
    assign fwdWr   = 1'b0;
    assign fwdSpec = 1'b0;
`endif
    assign rd_data[k*DATA_W +: DATA_W] = zeroHit ? DATA_W'(RST_VAL) :
                                         fwdWr   ? wr_data :
                                         fwdSpec ? spec_wr_data : regFile[addr];
    assign rd_busy[k] = pending[addr] && !fwdWr;
  end

  // Special-register view, forwarded the same way as the read ports
`ifdef REGFILE_SB_BYPASS_EN
  assign specFwdWr   = wrEff && (wr_addr == SPEC_IDX);
  assign specFwdSpec = specEff;
`else
  assign specFwdWr   = 1'b0;
  assign specFwdSpec = 1'b0;
`endif
  assign spec_data = specZero    ? DATA_W'(RST_VAL) :
                     specFwdWr   ? wr_data :
                     specFwdSpec ? spec_wr_data : regFile[SPEC_IDX];

  // Hazard: a valid read of a busy source, or issuing onto a still-pending destination
  always_comb begin
    stall = 1'b0;
    if ((rd_en & rd_busy) != '0) stall = 1'b1;
    if (issue_en && pending[issue_addr] && !(wr_en && (wr_addr == issue_addr))) stall = 1'b1;
  end

  regfile_sb_score #(
    .ADDR_W (ADDR_W)
  ) u_score (
    .clk     (clk),
    .rst     (rst),
    .setEn   (issueEff),
    .setAddr (issue_addr),
    .clrEn   (wrEff),
    .clrAddr (wr_addr),
    .errClr  (err_clr),
    .pending (pending),
    .pendCnt (pend_cnt),
    .wbErr   (wb_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: randomized and directed traffic against a behavioural model.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdData;
    logic [1:0]  busy;
    logic        stall;
    logic [15:0] specData;
    logic [4:0]  cnt;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  rd_en;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic [15:0] spec_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        spec_wr_en;
  logic [15:0] spec_wr_data;
  logic        issue_en;
  logic [3:0]  issue_addr;
  logic        stall;
  logic [4:0]  pend_cnt;
  logic        wb_err;
  logic        err_clr;

  logic [1:0]  z_rd_en;
  logic [7:0]  z_rd_addr;
  logic [31:0] z_rd_data;
  logic [1:0]  z_rd_busy;
  logic [15:0] z_spec_data;
  logic        z_wr_en;
  logic [3:0]  z_wr_addr;
  logic [15:0] z_wr_data;
  logic        z_issue_en;
  logic [3:0]  z_issue_addr;
  logic        z_stall;
  logic [4:0]  z_pend_cnt;
  logic        z_wb_err;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .spec_data(spec_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .spec_wr_en(spec_wr_en), .spec_wr_data(spec_wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .stall(stall), .pend_cnt(pend_cnt),
    .wb_err(wb_err), .err_clr(err_clr)
  );

  regfile_sb #(.ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst(rst), .rd_en(z_rd_en), .rd_addr(z_rd_addr), .rd_data(z_rd_data),
    .rd_busy(z_rd_busy), .spec_data(z_spec_data), .wr_en(z_wr_en), .wr_addr(z_wr_addr),
    .wr_data(z_wr_data), .spec_wr_en(1'b0), .spec_wr_data(16'h0),
    .issue_en(z_issue_en), .issue_addr(z_issue_addr), .stall(z_stall), .pend_cnt(z_pend_cnt),
    .wb_err(z_wb_err), .err_clr(1'b0)
  );

  int nChecks = 0;
  int nErr    = 0;

  // Behavioural model: architectural registers, pending flags, sticky error
  logic [15:0] mMem [16];
  bit          mPend [16];
  bit          mErr;
  exp_t        expQ [$];
  exp_t        monE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] mCount();
    int c = 0;
    for (int i = 0; i < 16; i++) if (mPend[i]) c++;
    return 5'(c);
  endfunction

  function automatic logic [15:0] mRead(input logic [3:0] a);
    if (BYP && wr_en && wr_addr == a) return wr_data;
    if (BYP && spec_wr_en && a == 4'd15) return spec_wr_data;
    return mMem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mMem[i]  = 16'h0;
      mPend[i] = 1'b0;
    end
    mErr = 1'b0;
  endtask

  task automatic idle_inputs();
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    spec_wr_en = 1'b0; spec_wr_data = '0; issue_en = 1'b0; issue_addr = '0; err_clr = 1'b0;
    z_rd_en = '0; z_rd_addr = '0; z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0;
    z_issue_en = 1'b0; z_issue_addr = '0;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Expected outputs for the current inputs go to the queue, then the model steps
  task automatic commit();
    exp_t e;
    bit   errNow;
    for (int k = 0; k < 2; k++) begin
      logic [3:0] a;
      a = rd_addr[k*4 +: 4];
      e.rdData[k*16 +: 16] = mRead(a);
      e.busy[k] = mPend[a] && !(BYP && wr_en && wr_addr == a);
    end
    e.specData = mRead(4'd15);
    e.stall = (rd_en[0] && e.busy[0]) || (rd_en[1] && e.busy[1]) ||
              (issue_en && mPend[issue_addr] && !(wr_en && wr_addr == issue_addr));
    e.cnt = mCount();
    e.err = mErr;
    expQ.push_back(e);
    errNow = wr_en && !mPend[wr_addr];
    if (spec_wr_en) mMem[15] = spec_wr_data;
    if (wr_en) begin
      mMem[wr_addr]  = wr_data;
      mPend[wr_addr] = 1'b0;
    end
    if (issue_en && !e.stall) mPend[issue_addr] = 1'b1;
    mErr = errNow ? 1'b1 : (err_clr ? 1'b0 : mErr);
  endtask

  task automatic rand_cycle();
    int pl [$];
    begin_cycle();
    for (int i = 0; i < 16; i++) if (mPend[i]) pl.push_back(i);
    issue_en     = 1'($urandom_range(0, 1));
    issue_addr   = 4'($urandom);
    wr_en        = ($urandom_range(0, 9) < 4);
    wr_addr      = (pl.size() > 0 && $urandom_range(0, 3) != 0) ?
                   4'(pl[$urandom_range(0, pl.size() - 1)]) : 4'($urandom);
    wr_data      = 16'($urandom);
    spec_wr_en   = ($urandom_range(0, 4) == 0);
    spec_wr_data = 16'($urandom);
    rd_en        = 2'($urandom);
    rd_addr      = 8'($urandom);
    err_clr      = ($urandom_range(0, 9) == 0);
    commit();
  endtask

  // Monitor: compare every queued expectation while the inputs are stable
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      chk("rd_data0",  32'(rd_data[15:0]),  32'(monE.rdData[15:0]));
      chk("rd_data1",  32'(rd_data[31:16]), 32'(monE.rdData[31:16]));
      chk("rd_busy",   32'(rd_busy),        32'(monE.busy));
      chk("stall",     32'(stall),          32'(monE.stall));
      chk("spec_data", 32'(spec_data),      32'(monE.specData));
      chk("pend_cnt",  32'(pend_cnt),       32'(monE.cnt));
      chk("wb_err",    32'(wb_err),         32'(monE.err));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #12 rst = 1'b1;

    for (int n = 0; n < 250; n++) rand_cycle();

    // Mid-cycle asynchronous reset, checked before any clock edge
    begin_cycle();
    #1 rst = 1'b0;
    rd_en = 2'b11; rd_addr = 8'h3A; issue_en = 1'b1; issue_addr = 4'd6;
    #2;
    chk("rst_rd_data",   rd_data,           32'h0);
    chk("rst_spec_data", 32'(spec_data),    32'h0);
    chk("rst_pend_cnt",  32'(pend_cnt),     32'h0);
    chk("rst_stall",     32'(stall),        32'h0);
    chk("rst_wb_err",    32'(wb_err),       32'h0);
    chk("rst_rd_busy",   32'(rd_busy),      32'h0);
    #3 rst = 1'b1;
    idle_inputs();
    model_reset();

    // RAW on r3, then writeback of r3
    begin_cycle(); issue_en = 1'b1; issue_addr = 4'd3; commit();
    begin_cycle(); rd_en = 2'b01; rd_addr = 8'h03; commit();
    #3 chk("raw_stall", 32'(stall), 32'h1);
    chk("raw_busy", 32'(rd_busy[0]), 32'h1);
    begin_cycle(); rd_en = 2'b01; rd_addr = 8'h03;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hA5A5; commit();
`ifdef REGFILE_SB_BYPASS_EN
    #3 chk("wb_fwd_data", 32'(rd_data[15:0]), 32'hA5A5);
    chk("wb_fwd_stall", 32'(stall), 32'h0);
`else
    #3 chk("wb_nofwd_stall", 32'(stall), 32'h1);
    chk("wb_nofwd_busy", 32'(rd_busy[0]), 32'h1);
`endif
    begin_cycle(); rd_en = 2'b01; rd_addr = 8'h03; commit();
    #3 chk("post_wb_stall", 32'(stall), 32'h0);
    chk("post_wb_data", 32'(rd_data[15:0]), 32'hA5A5);

    // Write collision on the special register
    begin_cycle(); wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h1111;
    spec_wr_en = 1'b1; spec_wr_data = 16'h2222; commit();
    begin_cycle(); rd_addr = 8'h0F; commit();
    #3 chk("coll_spec_data", 32'(spec_data), 32'h1111);
    chk("coll_rd_data", 32'(rd_data[15:0]), 32'h1111);

    // Re-issue r5 in the same cycle it retires
    begin_cycle(); issue_en = 1'b1; issue_addr = 4'd5; commit();
    begin_cycle(); issue_en = 1'b1; issue_addr = 4'd5;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h5555; commit();
    #3 chk("reissue_stall", 32'(stall), 32'h0);
    begin_cycle(); rd_addr = 8'h50; commit();
    #3 chk("reissue_cnt", 32'(pend_cnt), 32'h1);
    chk("reissue_busy", 32'(rd_busy[1]), 32'h1);

    // Sticky writeback error and its clear
    begin_cycle(); err_clr = 1'b1; commit();
    begin_cycle(); wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h7777; commit();
    #3 chk("err_cleared", 32'(wb_err), 32'h0);
    begin_cycle(); err_clr = 1'b1; commit();
    #3 chk("err_set", 32'(wb_err), 32'h1);
    begin_cycle(); commit();
    #3 chk("err_clr", 32'(wb_err), 32'h0);

    // Hardwired-zero r0 instance
    begin_cycle(); z_wr_en = 1'b1; z_wr_addr = 4'd0; z_wr_data = 16'hFFFF;
    z_issue_en = 1'b1; z_issue_addr = 4'd0; z_rd_en = 2'b11; z_rd_addr = 8'h00;
    #3 chk("z0_rd_same", z_rd_data, 32'h0);
    begin_cycle(); z_rd_en = 2'b11; z_rd_addr = 8'h00;
    #3 chk("z0_rd_data", z_rd_data, 32'h0);
    chk("z0_busy",      32'(z_rd_busy),   32'h0);
    chk("z0_pend_cnt",  32'(z_pend_cnt),  32'h0);
    chk("z0_stall",     32'(z_stall),     32'h0);
    chk("z0_wb_err",    32'(z_wb_err),    32'h0);
    chk("z0_spec_data", 32'(z_spec_data), 32'h0);

    for (int n = 0; n < 300; n++) rand_cycle();
    begin_cycle();
    @(negedge clk);
    #1 chk("queue_drained", 32'(expQ.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
